// File: rtl/fwd_reg_pipe.sv
// Forward-registered valid/ready pipeline: DEPTH register stages on the valid/data
// path, combinational ready chain, occupancy count and synchronous flush.
module fwd_reg_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             m_valid,
  input  logic [WIDTH-1:0] m_data,
  output logic             m_ready,
  output logic             s_valid,
  output logic [WIDTH-1:0] s_data,
  input  logic             s_ready,
  output logic [LW-1:0]    level
);

  logic [DEPTH-1:0] v_r;
  logic [WIDTH-1:0] d_r [DEPTH];
  logic [DEPTH-1:0] r_s;
  logic [DEPTH-1:0] src_v_s;
  logic [WIDTH-1:0] src_d_s [DEPTH];

  function automatic logic [LW-1:0] popcount(input logic [DEPTH-1:0] vec);
    logic [LW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + LW'(vec[i]);
    end
    return cnt;
  endfunction

  // Ready chain: a stage can load if it is empty or the stage after it can load.
  always_comb begin
    logic acc;
    acc = s_ready;
    r_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc    = ~v_r[i] | acc;
      r_s[i] = acc;
    end
  end

  // Source of each stage: the producer for stage 0, otherwise the previous stage.
  always_comb begin
    src_v_s[0] = m_valid;
    src_d_s[0] = m_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v_s[i] = v_r[i-1];
      src_d_s[i] = d_r[i-1];
    end
  end

  // Stage registers; data is only captured with a valid source so empty moves keep d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_r[i] <= '0;
      end
    end else if (flush) begin
      v_r <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_s[i]) begin
          v_r[i] <= src_v_s[i];
          if (src_v_s[i]) begin
            d_r[i] <= src_d_s[i];
          end
        end
      end
    end
  end

  assign m_ready = r_s[0] & ~flush;
  assign s_valid = v_r[DEPTH-1] & ~flush;
  assign s_data  = d_r[DEPTH-1];
  assign level   = popcount(v_r);

endmodule

// File: doc/fwd_reg_pipe.md
# fwd_reg_pipe

Forward-registered valid/ready pipeline of DEPTH register stages. It breaks the valid and data timing paths between a producer (m_*) and a consumer (s_*) at full throughput. The ready path stays combinational. It sits on long datapath routes where valid and data paths fail timing, and provides occupancy reporting and a synchronous flush.

## Interface
- WIDTH, 8, payload width in bits (≥1)
- DEPTH, 2, number of register stages (1..8)
- LW, $clog2(DEPTH+1), width of `level` (derived, not overridden)

- clk  input  1  clock; all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous clear of all stages
- m_valid  input  1  upstream valid
- m_data  input  WIDTH  upstream payload
- m_ready  output  1  upstream ready
- s_valid  output  1  downstream valid (registered)
- s_data  output  WIDTH  downstream payload (registered)
- s_ready  input  1  downstream ready
- level  output  LW  number of occupied stages, 0..DEPTH

## Operation
- Stage i = 0..DEPTH-1. Stage 0 is at the input and stage DEPTH-1 drives s_*. Each stage holds v[i] and d[i].
- Source of stage i is stage i-1. Stage 0's source is m_valid/m_data.
- Ready chain: r[DEPTH] = s_ready, r[i] = ~v[i] | r[i+1], m_ready = r[0] & ~flush.
- Per clock, when flush = 0 and r[i] = 1:
  - v[i] <= source valid.
  - d[i] <= source data, only when source valid = 1; otherwise d[i] holds.
- When r[i] = 0, stage i holds v[i] and d[i].
- s_valid = v[DEPTH-1] & ~flush; s_data = d[DEPTH-1].
- Handshakes:
  - Upstream transfer when m_valid & m_ready.
  - Downstream transfer when s_valid & s_ready.
  - Each accepted beat appears exactly once at s_*, in order, unmodified.
- Bubble collapse: an empty stage accepts from its source even while s_ready = 0, so gaps squeeze out under backpressure.
- Capacity: DEPTH beats. With all stages valid and s_ready = 0, m_ready = 0.
- Flush (synchronous, highest priority after reset):
  - In the flush cycle, m_ready = 0 and s_valid = 0, so no transfers occur on either side.
  - All v[i] <= 0; d[i] unchanged.
  - Any beats held in the pipe are discarded.
- level = popcount(v[0..DEPTH-1]), combinational from registers, unaffected by flush masking.
- m_valid must not drop and m_data must not change while m_valid & ~m_ready. The block guarantees the same stability on s_valid/s_data while s_valid & ~s_ready, except during flush.

## Timing
- Reset values: v[i] = 0, d[i] = 0, s_valid = 0, s_data = 0, level = 0, m_ready = 1 (if flush = 0).
- Reset is asynchronous assert and synchronous-edge release. Asserting mid-stream drops all beats immediately. The first beat is accepted on the first rising edge with rst_n = 1.
- Latency, empty pipe: beat accepted at edge N is valid at s_* after edge N+DEPTH-1. It is visible the cycle after edge N when DEPTH = 1, and DEPTH cycles after acceptance in general.
- Throughput: 1 beat/clk while s_ready = 1, with no bubbles inserted.
- Simultaneous events:
  - A full pipe with s_ready = 1 accepts upstream in the same cycle it emits downstream; level stays DEPTH.
  - flush together with m_valid: the beat is not accepted.
  - flush together with s_ready: nothing is emitted.
- Combinational paths:
  - s_ready -> m_ready passes through DEPTH AND/OR levels.
  - flush -> m_ready and flush -> s_valid are combinational.
  - Valid and data paths are fully registered.
  - If the ready path fails timing, pair this block with a ready-registered slice.

## Test plan
- Stream, DEPTH=2, s_ready = 1: m_data = 0x01..0x10 back-to-back -> s_data 0x01..0x10 in order, first s_valid 2 cycles after first acceptance, no gaps, level = 2 in steady state.
- Backpressure: stream with s_ready = 0 for 5 cycles mid-burst -> exactly DEPTH beats absorbed, m_ready = 0 after that, s_data stable, no loss or duplication on resume; randomized s_ready/m_valid run checked against a scoreboard.
- Bubble collapse, DEPTH=4:
  - Send beats 0xA1, gap, 0xA2, gap, 0xA3 with s_ready = 0 -> level reaches 3 and stages compact.
  - Release s_ready -> 0xA1, 0xA2, 0xA3 emitted on consecutive cycles.
- Flush: pipe holding 2 beats, flush = 1 for one cycle with m_valid = 1 and s_ready = 1 -> no transfer that cycle, level = 0 next cycle, then the next beat passes normally.
- Reset mid-operation: pipe full, assert rst_n low between edges -> s_valid = 0 and level = 0 immediately, m_ready = 1; stream restarts cleanly after release.
- DEPTH=1 and DEPTH=8 builds: repeat the stream and backpressure scenarios -> latencies of 1 and 8 cycles, capacities of 1 and 8, level width 1 and 4.
